// File: rtl/uart_tx_fifo_gen2_if.sv
// Bus between the APB register file and the UART transmit engine.
//
// Signals:
//   wr_en, wr_data        character push from the register file
//   char_len, parity_mode character format, sampled when a frame starts
//   stop2, brk            two-stop-bit select, line break request
//   tx                    serial output
//   txrdy, tx_empty       FIFO not full / engine fully idle
//   fifo_level, overflow  FIFO occupancy / dropped-write pulse
//   fsm_state             current transmitter state, for observation
//
// Handshake: wr_en is a one-clk push qualifier. txrdy is the registered
// "not full" indication. A push is accepted when the FIFO is not full, or
// when a pop happens in the same clk. Otherwise it is dropped and overflow
// pulses for one clk. There is no back-pressure beyond txrdy.
interface uart_tx_fifo_gen2_if #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        char_len;
    logic [2:0]        parity_mode;
    logic              stop2;
    logic              brk;
    logic              tx;
    logic              txrdy;
    logic              tx_empty;
    logic [FIFO_AW:0]  fifo_level;
    logic              overflow;
    logic [2:0]        fsm_state;

    modport master (
        output wr_en, wr_data, char_len, parity_mode, stop2, brk,
        input  tx, txrdy, tx_empty, fifo_level, overflow, fsm_state
    );

    modport slave (
        input  wr_en, wr_data, char_len, parity_mode, stop2, brk,
        output tx, txrdy, tx_empty, fifo_level, overflow, fsm_state
    );
endinterface

// File: rtl/uart_tx_fifo_gen2.sv
// UART transmit engine with an internal FIFO.
//
// The engine supports the following features:
//   - a run-time character length of 5..DATA_W bits
//   - none/odd/even/mark/space parity
//   - one or two stop bits
//   - line break generation
//
// Bit timing comes from baud_tick, which pulses once per bit period.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   baud_tick  one-clk pulse per bit period
//   bus        uart_tx_fifo_gen2_if slave: push side, frame config, status, tx
module uart_tx_fifo_gen2 #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    uart_tx_fifo_gen2_if.slave    bus
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [3:0]       LEN_MIN = 4'd5;
    localparam logic [3:0]       LEN_MAX = 4'(DATA_W);

    // Each state names the bit currently driven on tx.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BREAK  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP1  = 3'd5;
    localparam logic [2:0] S_STOP2  = 3'd6;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_n;
    logic               push, pop;
    logic [DATA_W-1:0]  head;

    // Transmitter state and the frame config latched at frame start
    logic [2:0]        state_q, state_n;
    logic              tx_q, tx_n;
    logic [DATA_W-1:0] sh_q, sh_n;
    logic [3:0]        cnt_q, cnt_n;
    logic              par_q, par_n;
    logic [3:0]        len_q, len_n;
    logic [2:0]        pm_q, pm_n;
    logic              s2_q, s2_n;

    // Registered status outputs
    logic txrdy_q, tx_empty_q, overflow_q;

    // Combinational helpers
    logic       frame_end, decide, par_en, par_fold, par_bit;
    logic [3:0] len_in;

    assign head = mem[rd_ptr_q];

    // Out-of-range character lengths clamp to the nearest legal bound.
    always_comb begin
        len_in = bus.char_len;
        if (bus.char_len < LEN_MIN) begin
            len_in = LEN_MIN;
        end else if (bus.char_len > LEN_MAX) begin
            len_in = LEN_MAX;
        end
    end

    // The last stop bit ends on a tick. At that point the same
    // break/pop/idle decision as IDLE is taken in the same clk. This lets
    // frames run back to back with no idle bit between them.
    always_comb begin
        frame_end = baud_tick &&
                    (((state_q == S_STOP1) && !s2_q) || (state_q == S_STOP2));
        decide    = (state_q == S_IDLE) || frame_end;
        pop       = decide && !bus.brk && baud_tick && (level_q != '0);
        // A pop in the same clk frees a slot, so a write to a full FIFO
        // still lands in that case.
        push      = bus.wr_en && ((level_q != DEPTH_L) || pop);
    end

    always_comb begin
        level_n = level_q;
        if (push && !pop) begin
            level_n = level_q + (FIFO_AW+1)'(1);
        end else if (pop && !push) begin
            level_n = level_q - (FIFO_AW+1)'(1);
        end
    end

    // Parity of all data bits including the one now leaving the shifter.
    always_comb begin
        par_fold = par_q ^ sh_q[0];
        par_en   = (pm_q >= 3'd1) && (pm_q <= 3'd4);
        par_bit  = 1'b0;
        case (pm_q)
            3'd1:    par_bit = ~par_fold;
            3'd2:    par_bit = par_fold;
            3'd3:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state_q;
        tx_n    = tx_q;
        sh_n    = sh_q;
        cnt_n   = cnt_q;
        par_n   = par_q;
        len_n   = len_q;
        pm_n    = pm_q;
        s2_n    = s2_q;
        if (decide) begin
            if (bus.brk) begin
                state_n = S_BREAK;
                tx_n    = 1'b0;
            end else if (pop) begin
                state_n = S_START;
                tx_n    = 1'b0;
                sh_n    = head;
                len_n   = len_in;
                pm_n    = bus.parity_mode;
                s2_n    = bus.stop2;
                par_n   = 1'b0;
                cnt_n   = 4'd0;
            end else begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        end else begin
            case (state_q)
                S_BREAK: begin
                    if (!bus.brk) begin
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        state_n = S_DATA;
                        tx_n    = sh_q[0];
                        cnt_n   = 4'd0;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        par_n = par_fold;
                        if (cnt_q < len_q - 4'd1) begin
                            cnt_n = cnt_q + 4'd1;
                            sh_n  = sh_q >> 1;
                            tx_n  = sh_q[1];
                        end else if (par_en) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP1;
                            tx_n    = 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        state_n = S_STOP1;
                        tx_n    = 1'b1;
                    end
                end
                S_STOP1: begin
                    // Only the two-stop-bit case reaches here on a tick.
                    if (baud_tick && s2_q) begin
                        state_n = S_STOP2;
                        tx_n    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO storage carries no reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            txrdy_q    <= 1'b1;
            tx_empty_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            level_q    <= level_n;
            txrdy_q    <= (level_n != DEPTH_L);
            tx_empty_q <= (state_n == S_IDLE) && (level_n == '0) && !bus.brk;
            overflow_q <= bus.wr_en && !push;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            sh_q    <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            len_q   <= '0;
            pm_q    <= '0;
            s2_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            tx_q    <= tx_n;
            sh_q    <= sh_n;
            cnt_q   <= cnt_n;
            par_q   <= par_n;
            len_q   <= len_n;
            pm_q    <= pm_n;
            s2_q    <= s2_n;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.txrdy      = txrdy_q;
    assign bus.tx_empty   = tx_empty_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.fsm_state  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_gen2.sv
// Bench for uart_tx_fifo_gen2: directed scenarios plus random traffic,
// compared every clk against a bit-list model of the serial line.
module tb_uart_tx_fifo_gen2;
    localparam int DATA_W  = 8;
    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic clk       = 1'b0;
    logic reset_n   = 1'b0;
    logic baud_tick = 1'b0;

    uart_tx_fifo_gen2_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) bus ();

    uart_tx_fifo_gen2 #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .bus       (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- baud tick generator ----------------
    int tick_div   = 16;
    int tick_cnt   = 0;
    bit tick_auto  = 1'b0;
    bit tick_force = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tick_auto) begin
                if (tick_cnt <= 0) begin
                    baud_tick = 1'b1;
                    tick_cnt  = tick_div - 1;
                end else begin
                    baud_tick = 1'b0;
                    tick_cnt--;
                end
            end else begin
                baud_tick = tick_force;
            end
        end
    end

    // ---------------- reference model ----------------
    // exp_q: characters held in the FIFO.
    // line_q: bits of the current frame still to be driven; the front is
    // the bit on the line now.
    logic [DATA_W-1:0] exp_q[$];
    logic              line_q[$];
    int                m_mode;   // 0 idle, 1 break, 2 frame
    logic              m_tx, m_ovf, m_empty;
    bit                chk_on = 1'b0;

    function automatic void model_reset();
        exp_q.delete();
        line_q.delete();
        m_mode  = 0;
        m_tx    = 1'b1;
        m_ovf   = 1'b0;
        m_empty = 1'b1;
    endfunction

    function automatic void build_frame(input logic [DATA_W-1:0] d);
        int len;
        int ones;
        len = int'(bus.char_len);
        if (len < 5) len = 5;
        if (len > DATA_W) len = DATA_W;
        line_q.delete();
        line_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < len; i++) begin
            line_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (bus.parity_mode)
            3'd1: line_q.push_back((ones % 2) == 0);
            3'd2: line_q.push_back((ones % 2) == 1);
            3'd3: line_q.push_back(1'b1);
            3'd4: line_q.push_back(1'b0);
            default: ;
        endcase
        line_q.push_back(1'b1);
        if (bus.stop2) line_q.push_back(1'b1);
    endfunction

    function automatic void model_step();
        bit tk;
        bit at_rest;
        tk      = baud_tick;
        at_rest = (m_mode == 0) || (m_mode == 2 && tk && line_q.size() == 1);
        if (at_rest) begin
            if (bus.brk) begin
                m_mode = 1;
                line_q.delete();
                m_tx = 1'b0;
            end else if (tk && exp_q.size() > 0) begin
                build_frame(exp_q.pop_front());
                m_mode = 2;
                m_tx   = line_q[0];
            end else begin
                m_mode = 0;
                line_q.delete();
                m_tx = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (!bus.brk) begin
                m_mode = 0;
                m_tx   = 1'b1;
            end
        end else if (tk) begin
            line_q.delete(0);
            m_tx = line_q[0];
        end
        m_ovf = 1'b0;
        if (bus.wr_en) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(bus.wr_data);
            else m_ovf = 1'b1;
        end
        m_empty = (m_mode == 0) && (exp_q.size() == 0) && !bus.brk;
    endfunction

    always @(posedge clk) begin
        if (reset_n) model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            check("tx", 32'(bus.tx), 32'(m_tx));
            check("fifo_level", 32'(bus.fifo_level), exp_q.size());
            check("txrdy", 32'(bus.txrdy), 32'(exp_q.size() < DEPTH));
            check("tx_empty", 32'(bus.tx_empty), 32'(m_empty));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [DATA_W-1:0] d);
        @(posedge clk);
        #2;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #2;
        bus.wr_en = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic [2:0] pm, input logic s2);
        @(posedge clk);
        #2;
        bus.char_len    = len;
        bus.parity_mode = pm;
        bus.stop2       = s2;
    endtask

    // Waits for the next clk edge that carries a tick, returns tx after it.
    task automatic tick_sample(output logic b);
        int n;
        n = 0;
        b = 1'bx;
        forever begin
            @(posedge clk);
            if (baud_tick) break;
            n++;
            if (n > 2000) begin
                check("tick_timeout", 32'd0, 32'd1);
                return;
            end
        end
        @(negedge clk);
        b = bus.tx;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus.tx_empty !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 20000) begin
                check("drain_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic b;
    logic exp_8n1 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic exp_7e2 [19] = '{0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 1,
                           0, 0, 1, 1, 0, 1, 0, 1};

    initial begin
        bus.wr_en       = 1'b0;
        bus.wr_data     = '0;
        bus.char_len    = 4'd8;
        bus.parity_mode = 3'd0;
        bus.stop2       = 1'b0;
        bus.brk         = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_txrdy", 32'(bus.txrdy), 32'd1);
        check("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        chk_on  = 1'b1;

        // 8N1, 0xA5, tick every 16 clk
        tick_div  = 16;
        tick_auto = 1'b1;
        push(8'hA5);
        for (int i = 0; i < 10; i++) begin
            tick_sample(b);
            check($sformatf("8n1_bit%0d", i), 32'(b), 32'(exp_8n1[i]));
        end
        tick_sample(b);
        check("8n1_tx_empty", 32'(bus.tx_empty), 32'd1);

        // 7E2 0x53, config switched to 5O1 mid-frame, then 0x16
        set_cfg(4'd7, 3'd2, 1'b1);
        push(8'h53);
        tick_sample(b);
        check("7e2_bit0", 32'(b), 32'(exp_7e2[0]));
        set_cfg(4'd5, 3'd1, 1'b0);
        push(8'h16);
        for (int i = 1; i < 19; i++) begin
            tick_sample(b);
            check($sformatf("7e2_5o1_bit%0d", i), 32'(b), 32'(exp_7e2[i]));
        end
        wait_empty();

        // FIFO full, overflow, simultaneous write and pop while full
        set_cfg(4'd8, 3'd0, 1'b0);
        tick_auto  = 1'b0;
        tick_force = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h30 + i));
        @(negedge clk);
        check("full_level", 32'(bus.fifo_level), DEPTH);
        check("full_txrdy", 32'(bus.txrdy), 32'd0);
        push(8'hEE);
        @(negedge clk);
        check("full_overflow", 32'(bus.overflow), 32'd1);
        check("full_level_after_drop", 32'(bus.fifo_level), DEPTH);
        @(negedge clk);
        check("overflow_one_clk", 32'(bus.overflow), 32'd0);
        @(posedge clk);
        #1 tick_force = 1'b1;
        #1 bus.wr_en = 1'b1;
        bus.wr_data = 8'h99;
        @(posedge clk);
        #1 tick_force = 1'b0;
        #1 bus.wr_en = 1'b0;
        @(negedge clk);
        check("wr_pop_level", 32'(bus.fifo_level), DEPTH);
        check("wr_pop_no_overflow", 32'(bus.overflow), 32'd0);
        tick_div  = 4;
        tick_cnt  = 0;
        tick_auto = 1'b1;
        wait_empty();

        // Break requested mid-frame
        tick_div = 6;
        push(8'h5A);
        push(8'hC3);
        repeat (3) tick_sample(b);
        @(posedge clk);
        #2 bus.brk = 1'b1;
        repeat (150) @(posedge clk);
        @(negedge clk);
        check("brk_line_low", 32'(bus.tx), 32'd0);
        check("brk_no_pop", 32'(bus.fifo_level), 32'd1);
        @(posedge clk);
        #2 bus.brk = 1'b0;
        @(negedge clk);
        check("brk_still_low", 32'(bus.tx), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("brk_release_high", 32'(bus.tx), 32'd1);
        tick_sample(b);
        check("brk_resume_start", 32'(b), 32'd0);
        wait_empty();

        // Reset during the data bits
        tick_div = 5;
        push(8'h00);
        push(8'h00);
        repeat (4) tick_sample(b);
        check("pre_reset_data_low", 32'(b), 32'd0);
        @(posedge clk);
        #4 reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_tx", 32'(bus.tx), 32'd1);
        check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        check("mid_rst_tx_empty", 32'(bus.tx_empty), 32'd1);
        check("mid_rst_txrdy", 32'(bus.txrdy), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        push(8'h3C);
        wait_empty();

        // Random traffic, config, break and tick rate
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #2;
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_data = DATA_W'($urandom);
            if ($urandom_range(0, 150) == 0) begin
                bus.char_len    = 4'($urandom_range(0, 15));
                bus.parity_mode = 3'($urandom_range(0, 7));
                bus.stop2       = 1'($urandom_range(0, 1));
            end
            if (!bus.brk) bus.brk = ($urandom_range(0, 600) == 0);
            else          bus.brk = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 500) == 0) tick_div = $urandom_range(1, 12);
        end
        @(posedge clk);
        #2;
        bus.wr_en = 1'b0;
        bus.brk   = 1'b0;
        wait_empty();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        check("watchdog", 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
